// File: rtl/flash_arbiter.sv
// Shares the single SPI flash read channel between icache and dcache misses.
// dcache has priority, with a starvation guard for icache and a watchdog abort.
module flash_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        icache_req,
  input  logic [19:0] icache_addr,
  input  logic        dcache_req,
  input  logic [19:0] dcache_addr,
  output logic        icache_valid,
  output logic        dcache_valid,
  output logic [31:0] rdata,
  output logic [1:0]  grant,
  output logic        spi_req,
  output logic [19:0] spi_addr,
  input  logic        spi_data_ready,
  input  logic [31:0] spi_data,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_D    = 2'd1;
  localparam logic [1:0] GRANT_I    = 2'd2;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WD_MAX     = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        spi_req_q, spi_req_d;
  logic [1:0]  grant_q, grant_d;
  logic [19:0] spi_addr_q, spi_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        icache_valid_q, icache_valid_d;
  logic        dcache_valid_q, dcache_valid_d;
  logic        timeout_err_q, timeout_err_d;

  logic pick_icache;
  logic granted_req;
  logic wd_expired;

  assign pick_icache = icache_req && (!dcache_req || starve_cnt_q == STARVE_MAX);
  assign granted_req = (grant_q == GRANT_I) ? icache_req : dcache_req;
  assign wd_expired  = (wd_cnt_q == WD_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      starve_cnt_q   <= '0;
      wd_cnt_q       <= '0;
      spi_req_q      <= 1'b0;
      grant_q        <= GRANT_NONE;
      spi_addr_q     <= '0;
      rdata_q        <= '0;
      icache_valid_q <= 1'b0;
      dcache_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      spi_req_q      <= spi_req_d;
      grant_q        <= grant_d;
      spi_addr_q     <= spi_addr_d;
      rdata_q        <= rdata_d;
      icache_valid_q <= icache_valid_d;
      dcache_valid_q <= dcache_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (icache_req || dcache_req) state_d = BUSY;
      BUSY:    if (!granted_req || spi_data_ready || wd_expired) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latches are inferred.
  always_comb begin
    starve_cnt_d   = starve_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    spi_req_d      = spi_req_q;
    grant_d        = grant_q;
    spi_addr_d     = spi_addr_q;
    rdata_d        = rdata_q;
    icache_valid_d = 1'b0;
    dcache_valid_d = 1'b0;
    timeout_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (icache_req || dcache_req) begin
          spi_req_d = 1'b1;
          wd_cnt_d  = '0;
          if (pick_icache) begin
            grant_d      = GRANT_I;
            spi_addr_d   = icache_addr;
            starve_cnt_d = '0;
          end else begin
            grant_d    = GRANT_D;
            spi_addr_d = dcache_addr;
            // Only count dcache wins that actually made icache wait.
            if (!icache_req)                     starve_cnt_d = '0;
            else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      BUSY: begin
        if (!granted_req) begin
          spi_req_d = 1'b0;
          grant_d   = GRANT_NONE;
        end else if (spi_data_ready) begin
          spi_req_d      = 1'b0;
          grant_d        = GRANT_NONE;
          rdata_d        = spi_data;
          icache_valid_d = (grant_q == GRANT_I);
          dcache_valid_d = (grant_q == GRANT_D);
        end else if (wd_expired) begin
          spi_req_d     = 1'b0;
          grant_d       = GRANT_NONE;
          timeout_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      default: begin
        spi_req_d = 1'b0;
        grant_d   = GRANT_NONE;
      end
    endcase
  end

  assign icache_valid = icache_valid_q;
  assign dcache_valid = dcache_valid_q;
  assign rdata        = rdata_q;
  assign grant        = grant_q;
  assign spi_req      = spi_req_q;
  assign spi_addr     = spi_addr_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Arbitrates the single SPI flash read channel between the instruction cache and the data cache. Sits between the two cache miss interfaces and `spi_controller`, presenting one request and one stable 20-bit CPU address at a time and returning the 32-bit read word to the granted cache. Applies dcache priority with a starvation guard for icache, plus an abort path and a watchdog timeout so a stuck flash transfer cannot hang either cache.

## Interface
- `STARVE_LIMIT`, default 4: consecutive dcache grants with icache pending before icache is forced; range 1..15.
- `TIMEOUT`, default 255: maximum cycles in BUSY without `spi_data_ready`; range 2..255.

- `CLK`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `icache_req`  in  1  icache miss; held high until `icache_valid` or withdrawn.
- `icache_addr`  in  20  icache miss address (CPU space).
- `dcache_req`  in  1  dcache miss; same rules.
- `dcache_addr`  in  20  dcache miss address.
- `icache_valid`  out  1  one-cycle pulse, `rdata` belongs to icache.
- `dcache_valid`  out  1  one-cycle pulse, `rdata` belongs to dcache.
- `rdata`  out  32  captured flash word, held until next capture.
- `grant`  out  2  0 none, 1 dcache, 2 icache (same encoding as SPI `mode`).
- `spi_req`  out  1  request to `spi_controller`.
- `spi_addr`  out  20  address to `spi_controller`, stable while `spi_req` high.
- `spi_data_ready`  in  1  word available on `spi_data`.
- `spi_data`  in  32  word from `spi_controller`.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts a transfer.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any req high, pick winner, latch its address into `spi_addr`, set `grant`, `spi_req`=1, go BUSY. Otherwise stay.
- Winner: dcache if only dcache; icache if only icache; if both, dcache unless `starve_cnt == STARVE_LIMIT`, then icache.
- `starve_cnt` (4 bits): +1 (saturating at STARVE_LIMIT) on a dcache grant while `icache_req` high; cleared on icache grant or dcache grant with `icache_req` low.
- BUSY, in priority order: (1) granted req low -> abort, no valid, go RELEASE; (2) `spi_data_ready` -> capture `spi_data` into `rdata`, pulse granted valid, go RELEASE; (3) `wd_cnt == TIMEOUT` -> pulse `timeout_err`, no valid, go RELEASE; (4) else `wd_cnt`+1.
- `wd_cnt` (8 bits) cleared on entry to BUSY.
- RELEASE: exactly one cycle, `spi_req`=0, `grant`=0, all reqs ignored; then IDLE. Guarantees the SPI controller sees its request drop and returns to idle.
- `spi_addr` changes only on a grant in IDLE; never while BUSY.
- Requesters drop req the cycle after their valid; a req still high in the IDLE following RELEASE is treated as a new miss.

## Timing
- Reset values: `spi_req`=0, `spi_addr`=0, `grant`=0, `rdata`=0, both valids 0, `timeout_err`=0, state IDLE, `starve_cnt`=0, `wd_cnt`=0. Reset mid-BUSY drops `spi_req` asynchronously; no valid or error pulse.
- All outputs registered.
- Req high in IDLE at edge N -> `spi_req`, `spi_addr`, `grant` valid after edge N (1-cycle latency).
- `spi_data_ready` high at edge M -> `rdata` and valid after edge M, valid low after M+1; `spi_req`/`grant` low after M.
- Back-to-back: earliest next `spi_req` is 2 cycles after valid (RELEASE + IDLE arbitration).
- Timeout: abort at the edge where `wd_cnt == TIMEOUT`, i.e. TIMEOUT+1 cycles after BUSY entry.
- Simultaneous data_ready with withdrawal: withdrawal wins, `rdata` not updated. Simultaneous data_ready with timeout: data wins.

## Test plan
- Single icache miss, addr 0x01234; `spi_data_ready` with 0xDEADBEEF 40 cycles later -> `spi_addr`=0x01234, `grant`=2 one cycle after req; `icache_valid` one pulse, `rdata`=0xDEADBEEF; `spi_req` low for RELEASE.
- Both reqs high together -> dcache served first (`grant`=1), icache next; with dcache re-requesting continuously, icache granted on the 5th arbitration (STARVE_LIMIT=4).
- dcache withdraws req mid-BUSY -> next cycle `spi_req`=0, no `dcache_valid`, `rdata` unchanged; pending icache granted 2 cycles later.
- No `spi_data_ready` for 256 cycles, TIMEOUT=255 -> `timeout_err` pulses once, no valid, state returns to IDLE via RELEASE.
- Assert `reset` mid-BUSY -> `spi_req`, `grant` 0 immediately; after release with no reqs, all outputs stay 0.
- `spi_data_ready` on same edge as withdrawal -> no valid, `rdata` holds previous value.
